mux_rd_arbiter: RTL and testbench

- Shares the single read port of the 1024-entry n-bit select mux (10-bit select) between N_REQ requesters.
- Each requester posts an address with a valid/ready handshake. The arbiter picks one requester at a time, round-robin.
- The arbiter drives the mux select from a register, captures the mux output, and returns it on a per-requester response handshake.
- Sits between register-file/memory-read clients and the mux datapath. It is the only driver of the mux select.

---
 rtl/mux_rd_arbiter.sv | 107 ++++++++++
 tb/tb_mux_rd_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rd_arbiter.sv
// Round-robin read-port arbiter for the 1024-entry select mux; fixed priority when MUX_RD_ARB_FIXED_PRIO_EN is defined.
// Latency: accept at t, response valid at t+2; requests stall (ready=0) while a read or response is in flight.
module mux_rd_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_REQ-1:0]  req_valid_i,
    input  logic [ADDR_W-1:0] req_addr_i [N_REQ],
    output logic [N_REQ-1:0]  req_ready_o,
    output logic [ADDR_W-1:0] mux_sel_o,
    input  logic [DATA_W-1:0] mux_data_i,
    output logic [N_REQ-1:0]  rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    input  logic [N_REQ-1:0]  rsp_ready_i,
    output logic              busy_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_last_gnt;
    logic [IDX_W-1:0]  r_wid;
    logic [IDX_W-1:0]  w_win;
    logic              w_any;
    logic [ADDR_W-1:0] r_sel;
    logic [DATA_W-1:0] r_data;

`ifdef MUX_RD_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last (winning) assignment.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[IDX_W'(i)]) begin
                w_win = IDX_W'(i);
                w_any = 1'b1;
            end
        end
    end
`else
    // Scan starts just past the last winner and wraps, so the last winner is checked last.
    always_comb begin
        int idx;
        idx   = 0;
        w_win = '0;
        w_any = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(r_last_gnt) + i) % N_REQ;
            if (!w_any && req_valid_i[IDX_W'(idx)]) begin
                w_win = IDX_W'(idx);
                w_any = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any) w_state_nxt = READ;
            READ:    w_state_nxt = RESP;
            RESP:    if (rsp_ready_i[r_wid]) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Ready is gated by reset so a held request cannot appear granted while in reset.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (r_state == IDLE && w_any && rst_ni) req_ready_o[w_win] = 1'b1;
        if (r_state == RESP) rsp_valid_o[r_wid] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_last_gnt <= IDX_W'(N_REQ - 1);
            r_wid      <= '0;
            r_sel      <= '0;
            r_data     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_any) begin
                r_sel      <= req_addr_i[w_win];
                r_last_gnt <= w_win;
                r_wid      <= w_win;
            end
            if (r_state == READ) r_data <= mux_data_i;
        end
    end

    assign mux_sel_o  = r_sel;
    assign rsp_data_o = r_data;
    assign busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_mux_rd_arbiter.sv
// Bench for mux_rd_arbiter: table-driven single transactions, contention, backpressure and reset sequences.
module tb_mux_rd_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [9:0] req_addr [4];
    logic [3:0] req_ready;
    logic [9:0] mux_sel;
    logic [3:0] mux_data;
    logic [3:0] rsp_valid;
    logic [3:0] rsp_data;
    logic [3:0] rsp_ready;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         id;
        logic [3:0] d;
    } exp_t;
    exp_t sb [$];
    int   exp_gnt [$];

    typedef struct {
        int         r;
        logic [9:0] a;
        logic [3:0] d;
        logic [3:0] rdy;
    } vec_t;
    vec_t vecs [5];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Mux model: entry k holds k mod 16.
    assign mux_data = mux_sel[3:0];

    mux_rd_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_ready_o (req_ready),
        .mux_sel_o   (mux_sel),
        .mux_data_i  (mux_data),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_ready_i (rsp_ready),
        .busy_o      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && req_ready[i]) sb.push_back('{i, req_addr[i][3:0]});
            end
            if ((rsp_valid & rsp_ready) != 4'b0) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rsp_id", 32'(rsp_valid), 32'(4'b0001 << e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.d));
                end
            end
        end
    end

    task automatic wait_idle();
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_contention(input logic [3:0] mask, input int n);
        int got;
        int last_cyc;
        int g;
        got      = 0;
        last_cyc = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) req_addr[i] = 10'(16 + i);
        req_valid = mask;
        for (int k = 0; k < 60 && got < n; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                g = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
                chk("gnt_onehot", 32'($onehot(req_ready)), 32'd1);
                chk("gnt_order", 32'(g), 32'(exp_gnt[got]));
                if (got > 0) chk("gnt_gap", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                got++;
            end
        end
        chk("gnt_count", 32'(got), 32'(n));
        @(posedge clk); #1;
        req_valid = 4'b0;
        wait_idle();
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        req_addr[v.r]  = v.a;
        req_valid[v.r] = 1'b1;
        #4;
        chk("vec_ready", 32'(req_ready), 32'(v.rdy));
        @(posedge clk); #1;
        req_valid = 4'b0;
        chk("vec_sel", 32'(mux_sel), 32'(v.a));
        chk("vec_busy_read", 32'(busy), 32'd1);
        chk("vec_no_rsp_read", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("vec_rsp_valid", 32'(rsp_valid), 32'(v.rdy));
        chk("vec_rsp_data", 32'(rsp_data), 32'(v.d));
        @(posedge clk); #1;
        chk("vec_idle", 32'(busy), 32'd0);
        chk("vec_rsp_drop", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2, 10'h3A7, 4'h7, 4'b0100};
        vecs[1] = '{0, 10'h000, 4'h0, 4'b0001};
        vecs[2] = '{0, 10'h3FF, 4'hF, 4'b0001};
        vecs[3] = '{1, 10'h155, 4'h5, 4'b0010};
        vecs[4] = '{3, 10'h2C8, 4'h8, 4'b1000};

        rst_n     = 1'b0;
        req_valid = 4'b0;
        rsp_ready = 4'hF;
        for (int i = 0; i < 4; i++) req_addr[i] = 10'h0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel", 32'(mux_sel), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Contention: pointer starts at N_REQ-1 after reset.
`ifdef MUX_RD_ARB_FIXED_PRIO_EN
        exp_gnt = '{0, 0, 0, 0, 0};
        run_contention(4'b1111, 5);
        exp_gnt = '{0, 0, 0, 0};
        run_contention(4'b1001, 4);
`else
        exp_gnt = '{0, 1, 2, 3, 0};
        run_contention(4'b1111, 5);
        exp_gnt = '{3, 0, 3, 0};
        run_contention(4'b1001, 4);
`endif

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // Response backpressure on requester 1 while requester 0 waits.
        @(posedge clk); #1;
        rsp_ready    = 4'b1101;
        req_addr[1]  = 10'h2B5;
        req_valid[1] = 1'b1;
        @(negedge clk);
        chk("bp_gnt1", 32'(req_ready), 32'b0010);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        req_addr[0]  = 10'h0AA;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk("bp_rdy_read", 32'(req_ready), 32'd0);
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'b0010);
            chk("bp_rsp_data", 32'(rsp_data), 32'h5);
            chk("bp_rdy_resp", 32'(req_ready), 32'd0);
            chk("bp_sel_hold", 32'(mux_sel), 32'h2B5);
        end
        @(posedge clk); #1;
        rsp_ready = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("bp_gnt0", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0;
        wait_idle();

        // Reset during READ discards the in-flight read.
        @(posedge clk); #1;
        req_addr[2]  = 10'h111;
        req_valid[2] = 1'b1;
        @(negedge clk);
        chk("rr_gnt2", 32'(req_ready), 32'b0100);
        @(posedge clk); #1;
        req_valid   = 4'b1001;
        req_addr[0] = 10'h05C;
        req_addr[3] = 10'h0F3;
        chk("rr_busy_read", 32'(busy), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rr_ready0", 32'(req_ready), 32'd0);
        chk("rr_rsp0", 32'(rsp_valid), 32'd0);
        chk("rr_busy0", 32'(busy), 32'd0);
        chk("rr_sel0", 32'(mux_sel), 32'd0);
        chk("rr_data0", 32'(rsp_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_winner0", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
